des_out_serializer: RTL and testbench

Buffers 64-bit results from `des_top` (`cipher_text` qualified by `valid_out`) in a small FIFO and unloads them as a byte stream, MSB first, over a valid/ready handshake. It sits on the output side of the DES core and lets a narrow, possibly stalling consumer (host bus or UART bridge) drain results at its own rate. When the buffer is exhausted it drops incoming results and flags an overflow.

---
 rtl/des_out_serializer_if.sv | 32 +++
 rtl/des_out_serializer.sv | 148 ++++++++++++++
 tb/tb_des_out_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/des_out_serializer_if.sv
// des_out_serializer_if
// Groups the result-input strobe, the byte-stream handshake and the status
// outputs of des_out_serializer.
//   des_valid/des_text   : 64-bit result strobe from the DES core
//   byte_out/byte_valid/byte_ready/byte_last : byte stream to the consumer
//   fifo_count/overflow/busy : buffer status
// The master modport is the serializer side; slave is the producer/consumer side.
interface des_out_serializer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          des_valid;
    logic [63:0]   des_text;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          byte_last;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          busy;

    modport master (
        input  des_valid, des_text, byte_ready,
        output byte_out, byte_valid, byte_last, fifo_count, overflow, busy
    );

    modport slave (
        output des_valid, des_text, byte_ready,
        input  byte_out, byte_valid, byte_last, fifo_count, overflow, busy
    );
endinterface

// File: rtl/des_out_serializer.sv
// des_out_serializer
// Buffers 64-bit DES results in a DEPTH-entry FIFO and unloads them MSB byte
// first over a valid/ready byte stream. Results arriving with no room are
// dropped and latch a sticky overflow flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : des_out_serializer_if.master (result input, byte stream, status)
//
// Shifter FSM:
//   state   | meaning
//   S_IDLE  | shifter empty, waiting for a FIFO entry
//   S_SHIFT | shifter holds a word, byte idx is on byte_out
module des_out_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    des_out_serializer_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [63:0]   shift_word;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;

    logic          fifo_empty;
    logic          fifo_full;
    logic          xfer;
    logic          pop;
    logic          push;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign xfer       = (state == S_SHIFT) && bus.byte_ready;

    // A write to a full FIFO is still accepted when the same edge pops,
    // since the popped slot frees up exactly as the new word lands.
    assign push = bus.des_valid && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SHIFT;
                    idx_nxt   = 3'd0;
                end
            end
            S_SHIFT: begin
                if (xfer) begin
                    if (idx == 3'd7) begin
                        idx_nxt = 3'd0;
                        // Reload straight from the FIFO so words stream
                        // without an idle cycle between them.
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_word <= '0;
        end else if (pop) begin
            shift_word <= mem[rd_ptr];
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.des_text;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bus.des_valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs depend on registered state only. ~idx equals 7-idx, so the
    // MSB byte is selected at idx 0.
    assign bus.byte_valid = (state == S_SHIFT);
    assign bus.byte_out   = bus.byte_valid ? shift_word[{~idx, 3'b000} +: 8] : 8'h00;
    assign bus.byte_last  = bus.byte_valid && (idx == 3'd7);
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = bus.byte_valid || !fifo_empty;

endmodule

// File: tb/tb_des_out_serializer.sv
// tb_des_out_serializer
// Scoreboard bench: expected bytes are queued when words are driven and
// compared as the serializer hands them off.
module tb_des_out_serializer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } exp_t;

    logic clk;
    logic rst;

    des_out_serializer_if #(.DEPTH(DEPTH)) bus ();

    des_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_bytes  = 0;
    int   cyc      = 0;
    int   first_xfer = -1;
    int   last_xfer  = -1;
    int   peak_count = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_byte;
    logic       prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b = w[63-8*i -: 8];
            e.l = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [63:0] w, input bit accept);
        bus.des_valid = 1'b1;
        bus.des_text  = w;
        if (accept) push_word(w);
        tick();
        bus.des_valid = 1'b0;
    endtask

    task automatic drain(input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            bus.byte_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
            tick();
        end
        check("drain_done", 64'((exp_q.size() == 0) && !bus.busy), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_out"},   64'(bus.byte_out),   64'd0);
        check({tag, "_byte_valid"}, 64'(bus.byte_valid), 64'd0);
        check({tag, "_byte_last"},  64'(bus.byte_last),  64'd0);
        check({tag, "_fifo_count"}, 64'(bus.fifo_count), 64'd0);
        check({tag, "_overflow"},   64'(bus.overflow),   64'd0);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.des_valid  = 1'b0;
        bus.byte_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (int'(bus.fifo_count) > peak_count) peak_count = int'(bus.fifo_count);
            if (prev_stall) begin
                check("hold_byte", 64'(bus.byte_out), 64'(prev_byte));
                check("hold_last", 64'(bus.byte_last), 64'(prev_last));
            end
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 64'(bus.byte_out), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("byte", 64'(bus.byte_out), 64'(e.b));
                    check("last", 64'(bus.byte_last), 64'(e.l));
                end
                n_bytes++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            prev_stall = bus.byte_valid && !bus.byte_ready;
            prev_byte  = bus.byte_out;
            prev_last  = bus.byte_last;
        end
    end

    initial begin
        rst            = 1'b1;
        bus.des_valid  = 1'b0;
        bus.des_text   = '0;
        bus.byte_ready = 1'b0;
        tick();
        check_reset_vals("rst0");
        tick();
        rst = 1'b0;
        tick();

        // Single word with latency checks
        bus.byte_ready = 1'b1;
        send(64'h85E8_1354_0F0A_B405, 1'b1);
        check("lat1_count", 64'(bus.fifo_count), 64'd1);
        check("lat1_valid", 64'(bus.byte_valid), 64'd0);
        tick();
        check("lat2_valid", 64'(bus.byte_valid), 64'd1);
        check("lat2_count", 64'(bus.fifo_count), 64'd0);
        drain(0, 40);
        check("t1_busy_low", 64'(bus.busy), 64'd0);

        // Backpressure 1,0,0 pattern
        n_bytes = 0;
        bus.byte_ready = 1'b0;
        send(64'h85E8_1354_0F0A_B405, 1'b1);
        drain(1, 100);
        check("t2_nbytes", 64'(n_bytes), 64'd8);

        // Back-to-back words
        n_bytes    = 0;
        first_xfer = -1;
        peak_count = 0;
        bus.byte_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 1'b1);
        send(64'h1111_1111_1111_1111, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        drain(0, 80);
        check("t3_nbytes", 64'(n_bytes), 64'd24);
        check("t3_no_gap", 64'(last_xfer - first_xfer), 64'd23);
        check("t3_peak", 64'(peak_count), 64'd2);

        // Overflow
        n_bytes = 0;
        bus.byte_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(64'(i), i <= 5);
        check("t4_count", 64'(bus.fifo_count), 64'd4);
        check("t4_overflow", 64'(bus.overflow), 64'd1);
        drain(0, 100);
        check("t4_nbytes", 64'(n_bytes), 64'd40);
        check("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

        // Simultaneous write and pop at index-7 transfer
        do_reset();
        check_reset_vals("rst1");
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(64'hC0DE_0000_0000_0000 + 64'(i), 1'b1);
        check("t5_full", 64'(bus.fifo_count), 64'd4);
        bus.byte_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.byte_last) break;
            tick();
        end
        check("t5_at_last", 64'(bus.byte_last), 64'd1);
        send(64'hC0DE_0000_0000_0055, 1'b1);
        check("t5_count", 64'(bus.fifo_count), 64'd4);
        check("t5_overflow", 64'(bus.overflow), 64'd0);
        drain(0, 100);

        // Reset mid-stream
        bus.byte_ready = 1'b0;
        send(64'h1010_1010_1010_1010, 1'b1);
        send(64'h2020_2020_2020_2020, 1'b1);
        send(64'h3030_3030_3030_3030, 1'b1);
        check("t6_queued", 64'(bus.fifo_count), 64'd2);
        bus.byte_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_byte3", 64'(bus.byte_out), 64'h10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        exp_q.delete();
        tick();
        rst = 1'b0;
        bus.byte_ready = 1'b1;
        n_bytes = 0;
        send(64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        drain(0, 40);
        check("t6_nbytes", 64'(n_bytes), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
